cpu_sequencer: RTL and testbench

//   Fetch/execute control unit for the Harvard 1-port CPU; owns PC, IR, carry and skip flags.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/cpu_flag_reg.sv | 30 +++
 rtl/cpu_sequencer.sv | 105 ++++++++++
 tb/tb_cpu_sequencer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg : state encoding, opcode classes and reset defaults for the CPU
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  localparam logic [1:0] ST_FETCH   = 2'b00;
  localparam logic [1:0] ST_EXEC1   = 2'b01;
  localparam logic [1:0] ST_EXEC2   = 2'b10;
  localparam logic [1:0] ST_ILLEGAL = 2'b11;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_LDST = 2'b10;
  localparam logic [1:0] OP_ARM  = 2'b11;

  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

endpackage

`default_nettype wire

// File: rtl/cpu_flag_reg.sv
// ---------------------------------------------------------------------------
// cpu_flag_reg : carry and skip flag registers with load enables
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_flag_reg (
  input  logic clk,
  input  logic reset,
  input  logic cy_en,
  input  logic cy_d,
  input  logic skip_en,
  input  logic skip_d,
  output logic cy,
  output logic skip
);

  always_ff @(posedge clk) begin
    if (reset) begin
      cy   <= 1'b0;
      skip <= 1'b0;
    end else begin
      if (cy_en)   cy   <= cy_d;
      if (skip_en) skip <= skip_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer : FETCH/EXEC1/EXEC2 control unit owning PC, IR and flags
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [15:0]     inst,
  output logic            exec1,
  output logic            exec2,
  output logic            cy_status,
  output logic            skip_status,
  input  logic            alu_wen,
  input  logic            alu_cy_out,
  input  logic            alu_cy_en,
  input  logic            alu_skip_out,
  input  logic            alu_skip_en,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ready,
  output logic            rf_wen,
  output logic [1:0]      state_dbg
);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [PC_W-1:0] pc;
  logic [15:0]     ir;
  logic [PC_W-1:0] jmp_off;
  logic            in_exec1;
  logic            in_exec2;
  logic            fetch_go;
  logic            squash;
  logic            is_ldst;
  logic            is_jmp;

  assign in_exec1 = (state == ST_EXEC1);
  assign in_exec2 = (state == ST_EXEC2);
  assign fetch_go = (state == ST_FETCH) && run;
  assign squash   = fetch_go && skip_status;
  assign is_ldst  = (ir[15:14] == OP_LDST);
  assign is_jmp   = (ir[15:14] == OP_JMP);
  assign jmp_off  = {{(PC_W-12){ir[11]}}, ir[11:0]};

  always_comb begin
    state_nxt = ST_FETCH;
    case (state)
      ST_FETCH: state_nxt = (run && !skip_status) ? ST_EXEC1 : ST_FETCH;
      ST_EXEC1: state_nxt = is_ldst ? ST_EXEC2 : ST_FETCH;
      ST_EXEC2: state_nxt = mem_ready ? ST_FETCH : ST_EXEC2;
      default:  state_nxt = ST_FETCH;
    endcase
  end

  // The JMP offset is applied to the pc already incremented during FETCH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (fetch_go) begin
        ir <= imem_data;
        pc <= pc + PC_W'(1);
      end else if (in_exec1 && is_jmp) begin
        pc <= pc + jmp_off;
      end
    end
  end

  cpu_flag_reg u_flags (
    .clk     (clk),
    .reset   (reset),
    .cy_en   (in_exec1 && alu_cy_en),
    .cy_d    (alu_cy_out),
    .skip_en ((in_exec1 && alu_skip_en) || squash),
    .skip_d  (squash ? 1'b0 : alu_skip_out),
    .cy      (cy_status),
    .skip    (skip_status)
  );

  // Strobes are masked by reset so nothing leaks out while reset is held.
  assign exec1     = in_exec1 && !reset;
  assign exec2     = in_exec2 && !reset;
  assign mem_req   = exec2;
  assign mem_we    = exec2 && ir[13];
  assign rf_wen    = (exec1 && alu_wen) || (exec2 && mem_ready && !ir[13]);
  assign imem_addr = pc;
  assign inst      = ir;
  assign state_dbg = state;

endmodule

`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer : directed self-checking bench for cpu_sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, mem_ready;
  logic        alu_wen, alu_cy_out, alu_cy_en, alu_skip_out, alu_skip_en;
  logic [15:0] imem_addr, imem_data, inst;
  logic        exec1, exec2, cy_status, skip_status, mem_req, mem_we, rf_wen;
  logic [1:0]  state_dbg;
  logic [15:0] rom [16];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign imem_data = rom[imem_addr[3:0]];

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .imem_addr(imem_addr), .imem_data(imem_data),
    .inst(inst), .exec1(exec1), .exec2(exec2), .cy_status(cy_status),
    .skip_status(skip_status), .alu_wen(alu_wen), .alu_cy_out(alu_cy_out),
    .alu_cy_en(alu_cy_en), .alu_skip_out(alu_skip_out), .alu_skip_en(alu_skip_en),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ready(mem_ready), .rf_wen(rf_wen),
    .state_dbg(state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic alu_idle();
    alu_wen = 0; alu_cy_out = 0; alu_cy_en = 0; alu_skip_out = 0; alu_skip_en = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'h0000;
    reset = 1; run = 0; mem_ready = 0;
    alu_idle();

    // Reset state
    tick(); tick();
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_pc", 32'(imem_addr), 32'h0000);
    check("rst_inst", 32'(inst), 32'h0000);
    check("rst_flags", {30'd0, cy_status, skip_status}, 32'd0);
    check("rst_strobes", {28'd0, exec1, exec2, mem_req, rf_wen}, 32'd0);

    // 1: reset during EXEC2 with mem_ready low
    rom[0] = 16'h8000;
    reset = 0; run = 1;
    tick();
    check("t1_exec1_state", 32'(state_dbg), 32'd1);
    alu_cy_en = 1; alu_cy_out = 1; alu_skip_en = 1; alu_skip_out = 1;
    tick();
    alu_idle();
    settle();
    check("t1_exec2_memreq", {30'd0, mem_req, exec2}, 32'd3);
    check("t1_flags_set", {30'd0, cy_status, skip_status}, 32'd3);
    reset = 1;
    settle();
    check("t1_memreq_in_reset", 32'(mem_req), 32'd0);
    tick();
    check("t1_post_pc", 32'(imem_addr), 32'h0000);
    check("t1_post_state", 32'(state_dbg), 32'd0);
    check("t1_post_memreq", 32'(mem_req), 32'd0);
    check("t1_post_flags", {30'd0, cy_status, skip_status}, 32'd0);
    reset = 0;

    // 2: ARM add with carry out
    rom[0] = 16'hC000;
    tick();
    alu_wen = 1; alu_cy_en = 1; alu_cy_out = 1; alu_skip_en = 1; alu_skip_out = 0;
    settle();
    check("t2_exec1", 32'(exec1), 32'd1);
    check("t2_rf_wen", 32'(rf_wen), 32'd1);
    check("t2_cy_not_yet", 32'(cy_status), 32'd0);
    tick();
    alu_idle();
    settle();
    check("t2_cy_set", 32'(cy_status), 32'd1);
    check("t2_pc", 32'(imem_addr), 32'h0001);
    check("t2_fetch_rf_wen", 32'(rf_wen), 32'd0);

    // 3: ARM sets skip; following JMP is squashed
    rom[1] = 16'hC000;
    rom[2] = 16'h4003;
    tick();
    alu_skip_en = 1; alu_skip_out = 1;
    tick();
    alu_idle();
    check("t3_skip_set", 32'(skip_status), 32'd1);
    check("t3_pc_mid", 32'(imem_addr), 32'h0002);
    tick();
    check("t3_squash_state", 32'(state_dbg), 32'd0);
    check("t3_squash_exec1", 32'(exec1), 32'd0);
    check("t3_pc", 32'(imem_addr), 32'h0003);
    check("t3_skip_clr", 32'(skip_status), 32'd0);
    check("t3_cy_stable", 32'(cy_status), 32'd1);

    // 4: load with three wait cycles, then a store
    rom[3] = 16'h8000;
    rom[4] = 16'hA000;
    tick();
    check("t4_exec1_no_exec2", {30'd0, exec1, exec2}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_wait", {28'd0, exec2, mem_req, mem_we, rf_wen}, 32'b1100);
    end
    tick();
    mem_ready = 1;
    settle();
    check("t4_last", {28'd0, exec2, mem_req, mem_we, rf_wen}, 32'b1101);
    tick();
    mem_ready = 0;
    settle();
    check("t4_done", {29'd0, state_dbg, mem_req}, 32'd0);
    tick(); tick();
    mem_ready = 1;
    settle();
    check("t4_store", {28'd0, exec2, mem_req, mem_we, rf_wen}, 32'b1110);
    tick();
    mem_ready = 0;
    check("t4_store_pc", 32'(imem_addr), 32'h0005);

    // 5: backward JMP, then JMP to FFFF and wrap
    rom[5] = 16'h4FFE;
    tick(); tick();
    check("t5_jmp_back", 32'(imem_addr), 32'h0004);
    rom[4]  = 16'h4FFA;
    rom[15] = 16'h4000;
    tick(); tick();
    check("t5_jmp_ffff", 32'(imem_addr), 32'hFFFF);
    tick();
    check("t5_inc_wrap", 32'(imem_addr), 32'h0000);
    tick();
    check("t5_jmp_wrap", 32'(imem_addr), 32'h0000);

    // 6: run dropped during EXEC1
    rom[0] = 16'hC000;
    rom[1] = 16'hC000;
    tick();
    run = 0;
    settle();
    check("t6_exec1", 32'(exec1), 32'd1);
    tick();
    tick();
    tick();
    check("t6_park", {13'd0, state_dbg, exec1, imem_addr}, {13'd0, 2'd0, 1'b0, 16'h0001});
    run = 1;
    tick();
    check("t6_resume", {14'd0, state_dbg, imem_addr}, {14'd0, 2'd1, 16'h0002});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
